sram_128x64_arb2: RTL and testbench
===================================

# sram_128x64_arb2

Two-requester controller for one 128x64 single-port SRAM. It clears the array after reset, round-robin arbitrates per-cycle read/write requests from two clients, and returns read data through one-entry per-port response registers with valid/ready handshakes. It sits between two cache/buffer clients and a `sram_128x64` instance, which it owns.

## Interface
- `CLEAR_ON_RESET`, 1: run the clear sweep after reset (0 = go straight to RUN).
- `CLEAR_VALUE`, 64'h0: word written to every line during the clear sweep.
- `i_clk  in  1  clock`
- `i_rst_n  in  1  reset; asynchronous, active-low`
- `i_req_valid  in  2  request valid, bit p = port p`
- `o_req_ready  out  2  request accepted when valid&ready`
- `i_req_we  in  2  1 = write, 0 = read`
- `i_req_addr  in  14  port p at [7p+6:7p]`
- `i_req_wdata  in  128  port p at [64p+63:64p]`
- `i_req_mask  in  128  write bit-mask, 1 = bit written; port p at [64p+63:64p]`
- `o_rsp_valid  out  2  read data valid`
- `i_rsp_ready  in  2  consumer accepts response`
- `o_rsp_rdata  out  128  port p at [64p+63:64p]`
- `o_init_done  out  1  clear sweep finished`

## Operation
- FSM states and transitions:
  - Reset enters CLEAR if `CLEAR_ON_RESET`=1, else RUN.
  - CLEAR: a 7-bit counter writes `CLEAR_VALUE` with the full mask to addresses 0..127, one per cycle. After address 127 is written, the FSM moves to RUN. `o_req_ready`=0 throughout.
  - RUN: arbitration is active. RUN is terminal until reset.
- SRAM drive:
  - Enable and write-enable are active-high.
  - Driven combinationally from the granted request, or from the clear counter in CLEAR.
  - Enable is 0 when there is no grant.
- Arbitration:
  - One grant per cycle.
  - Port p is eligible when `i_req_valid[p]` is set and, for reads, its response slot is free.
  - Response slot free means: no read in flight for p, and `o_rsp_valid[p]`=0 or `i_rsp_ready[p]`=1 in the same cycle.
  - Writes are always eligible in RUN.
  - If both ports are eligible, the priority pointer decides. The pointer resets to port 0 and points to the other port after every grant.
  - A single eligible port wins regardless of the pointer.
  - `o_req_ready[p]` = grant[p].
- Reads:
  - Accepting a read sets `inflight[p]`.
  - The next cycle, SRAM data is captured into `rsp_data[p]`, `o_rsp_valid[p]` is set and `inflight[p]` is cleared.
- Writes produce no response.
- Response registers hold value and valid until `i_rsp_ready[p]`. A pop and a new capture may coincide only when the pointer logic above allowed the grant.
- Reset asserted mid-operation: in-flight reads and held responses are discarded; the clear sweep restarts.

## Timing
- Reset values:
  - `o_req_ready`=0, `o_rsp_valid`=0, `o_rsp_rdata`=0
  - `o_init_done`=0 if `CLEAR_ON_RESET`, else 1
  - pointer=0, inflight=0, counter=0
- Clear sweep: 128 cycles after reset deassertion. `o_init_done` rises in cycle 128 and stays high.
- Read latency:
  - Accept in cycle T; `o_rsp_valid` high from cycle T+2.
  - Minimum same-port read issue interval is 2 cycles.
  - Writes sustain 1 per cycle. The aggregate across ports is 1 access per cycle.
- Read-after-write: a write accepted in T, followed by a read of the same address accepted in T+1 (either port), returns the new data.
- `o_req_ready` depends combinationally on `i_req_valid`, `i_req_we` and `i_rsp_ready`. There is no combinational path from any input to `o_rsp_*`.

## Structure
- Package `sram_ctrl_pkg`:
  - `DEPTH`=128, `AW`=7, `DW`=64, `NPORT`=2
  - `state_e {ST_CLEAR, ST_RUN}`
  - packed request struct `{we, addr, wdata, mask}`
- One sub-module: `sram_128x64`, instantiated once. Clock `i_clk`, enable/write-enable/mask/address/wdata from the mux, read data to the capture registers.
- Arbiter, clear counter and response slots stay in the top-level module, roughly 200 lines.

## Test plan
- Reset with `CLEAR_ON_RESET`=1, preload garbage via backdoor -> `o_init_done` at cycle 128; a read of addr 0x7F on port 0 returns 64'h0.
- Both ports continuously request writes -> grants alternate 0,1,0,1; after reset port 0 is granted first; all 128 writes land.
- Port 0 writes 64'hFFFF_FFFF_FFFF_FFFF to 0x05, then writes 64'h0 with mask 64'h0000_0000_FFFF_FFFF, then reads -> 64'hFFFF_FFFF_0000_0000 at T+2.
- Port 1 read with `i_rsp_ready[1]`=0 for 10 cycles -> data held stable and `o_rsp_valid[1]`=1; further port-1 reads are not accepted; port-0 traffic continues unblocked.
- Write 0x3 to 0x10 in cycle T, read 0x10 from the other port in T+1 -> 0x3 returned.
- Assert `i_rst_n` low while reads are in flight -> `o_rsp_valid`=0 immediately, the clear sweep reruns, and no stale response appears afterwards.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared geometry, FSM state and request type for the 128x64 SRAM controller
package sram_ctrl_pkg;
    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int DW    = 64;
    localparam int NPORT = 2;

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mask;
    } req_t;
endpackage

// File: rtl/sram_128x64.sv
// sram_128x64: single-port 128x64 SRAM, bit-masked writes, registered read data
module sram_128x64
    import sram_ctrl_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    input  logic [DW-1:0] i_mask,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en && i_we)
            r_mem[i_addr] <= (r_mem[i_addr] & ~i_mask) | (i_wdata & i_mask);
        if (i_en && !i_we)
            r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/sram_128x64_arb2.sv
// sram_128x64_arb2: clears the SRAM after reset, then round-robin arbitrates two ports with one-entry read response slots
module sram_128x64_arb2
    import sram_ctrl_pkg::*;
#(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [63:0] CLEAR_VALUE    = 64'h0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NPORT-1:0]      i_req_valid,
    output logic [NPORT-1:0]      o_req_ready,
    input  logic [NPORT-1:0]      i_req_we,
    input  logic [NPORT*AW-1:0]   i_req_addr,
    input  logic [NPORT*DW-1:0]   i_req_wdata,
    input  logic [NPORT*DW-1:0]   i_req_mask,
    output logic [NPORT-1:0]      o_rsp_valid,
    input  logic [NPORT-1:0]      i_rsp_ready,
    output logic [NPORT*DW-1:0]   o_rsp_rdata,
    output logic                  o_init_done
);
    state_e                      r_state;
    logic [AW-1:0]               r_cnt;
    logic                        r_init_done;
    logic                        r_ptr;
    logic [NPORT-1:0]            r_inflight;
    logic [NPORT-1:0]            r_rsp_valid;
    logic [NPORT-1:0][DW-1:0]    r_rsp_data;

    req_t                        w_req [NPORT];
    req_t                        w_sel;
    logic [NPORT-1:0]            w_free;
    logic [NPORT-1:0]            w_elig;
    logic [NPORT-1:0]            w_grant;
    logic                        w_clear;
    logic                        w_run;
    logic                        w_en;
    logic                        w_we;
    logic [AW-1:0]               w_addr;
    logic [DW-1:0]               w_wdata;
    logic [DW-1:0]               w_mask;
    logic [DW-1:0]               w_rdata;

    assign w_clear = (r_state == ST_CLEAR);
    assign w_run   = (r_state == ST_RUN);

    genvar p;
    generate
        for (p = 0; p < NPORT; p++) begin : g_port
            assign w_req[p] = '{we:    i_req_we[p],
                                addr:  i_req_addr[AW*p +: AW],
                                wdata: i_req_wdata[DW*p +: DW],
                                mask:  i_req_mask[DW*p +: DW]};
            // A read may only issue if its response has somewhere to land next cycle
            assign w_free[p] = !r_inflight[p] && (!r_rsp_valid[p] || i_rsp_ready[p]);
            assign w_elig[p] = w_run && i_req_valid[p] && (i_req_we[p] || w_free[p]);
        end
    endgenerate

    assign w_grant[0]  = w_elig[0] && (!w_elig[1] || !r_ptr);
    assign w_grant[1]  = w_elig[1] && (!w_elig[0] ||  r_ptr);
    assign o_req_ready = w_grant;
    assign w_sel       = w_grant[1] ? w_req[1] : w_req[0];

    always_comb begin
        w_en    = w_clear || (|w_grant);
        w_we    = w_clear || w_sel.we;
        w_addr  = w_clear ? r_cnt       : w_sel.addr;
        w_wdata = w_clear ? CLEAR_VALUE : w_sel.wdata;
        w_mask  = w_clear ? '1          : w_sel.mask;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            r_cnt       <= '0;
            r_init_done <= !CLEAR_ON_RESET;
            r_ptr       <= 1'b0;
            r_inflight  <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (w_clear) begin
                r_cnt <= r_cnt + 1'b1;
                if (&r_cnt) begin
                    r_state     <= ST_RUN;
                    r_init_done <= 1'b1;
                end
            end
            if (|w_grant)
                r_ptr <= w_grant[0];
            r_inflight  <= w_grant & ~i_req_we;
            r_rsp_valid <= r_inflight | (r_rsp_valid & ~i_rsp_ready);
            for (int i = 0; i < NPORT; i++)
                if (r_inflight[i])
                    r_rsp_data[i] <= w_rdata;
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_data;
    assign o_init_done = r_init_done;

    sram_128x64 u_sram (
        .i_clk   (i_clk),
        .i_en    (w_en),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .i_mask  (w_mask),
        .o_rdata (w_rdata)
    );
endmodule

// File: tb/tb_sram_128x64_arb2.sv
// tb_sram_128x64_arb2: directed vectors for the two-port SRAM controller
module tb_sram_128x64_arb2;
    import sram_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_we = '0;
    logic [13:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [127:0] req_mask = '0;
    logic [1:0]   rsp_ready = 2'b11;
    logic [1:0]   req_ready;
    logic [1:0]   rsp_valid;
    logic [127:0] rsp_rdata;
    logic         init_done;
    int           n_chk = 0;
    int           n_pass = 0;
    logic         seen_v;
    logic         seen_r;

    always #5 clk = ~clk;

    sram_128x64_arb2 #(.CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(64'h0)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_mask  (req_mask),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rsp_rdata),
        .o_init_done (init_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] pat(input int a);
        return 64'h5A5A_0000_0000_0000 | (64'(a) * 64'h0001_0001_0001);
    endfunction

    task automatic drive(input int p, input logic v, input logic we, input logic [6:0] a,
                         input logic [63:0] d, input logic [63:0] m);
        req_valid[p]          = v;
        req_we[p]             = we;
        req_addr[7*p +: 7]    = a;
        req_wdata[64*p +: 64] = d;
        req_mask[64*p +: 64]  = m;
    endtask

    task automatic rd(input int p, input logic [6:0] a, input logic [63:0] exp, input string tag);
        drive(p, 1'b1, 1'b0, a, 64'h0, 64'h0);
        #1 check({tag, "_rdy"}, req_ready[p], 1);
        @(negedge clk);
        req_valid[p] = 1'b0;
        #1 check({tag, "_v1"}, rsp_valid[p], 0);
        @(negedge clk);
        #1 check({tag, "_v2"}, rsp_valid[p], 1);
        check(tag, rsp_rdata[64*p +: 64], exp);
        @(negedge clk);
    endtask

    initial begin
        drive(0, 1'b1, 1'b1, 7'h00, pat(0), '1);
        drive(1, 1'b1, 1'b1, 7'h40, pat(64), '1);
        #1;
        check("rst_rdy", req_ready, 0);
        check("rst_rv", rsp_valid, 0);
        check("rst_rd0", rsp_rdata[63:0], 0);
        check("rst_rd1", rsp_rdata[127:64], 0);
        check("rst_init", init_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c < 128; c++) begin
            @(negedge clk);
            if (c == 64) #1 check("clr_rdy", req_ready, 0);
        end
        #1 check("init127", init_done, 0);
        @(negedge clk);
        #1 check("init128", init_done, 1);
        check("clr_mem7f", dut.u_sram.r_mem[127], 64'h0);

        // Both ports stream writes; grants must alternate starting with port 0
        for (int c = 0; c < 128; c++) begin
            drive(0, 1'b1, 1'b1, 7'(c / 2), pat(c / 2), '1);
            drive(1, 1'b1, 1'b1, 7'(64 + c / 2), pat(64 + c / 2), '1);
            #1 check($sformatf("arb%0d", c), req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge clk);
        end
        req_valid = '0;
        for (int a = 0; a < 128; a++)
            check($sformatf("mem%0d", a), dut.u_sram.r_mem[a], pat(a));

        drive(0, 1'b1, 1'b1, 7'h05, '1, '1);
        #1 check("mask_w1", req_ready, 2'b01);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 7'h05, 64'h0, 64'h0000_0000_FFFF_FFFF);
        #1 check("mask_w2", req_ready, 2'b01);
        @(negedge clk);
        rd(0, 7'h05, 64'hFFFF_FFFF_0000_0000, "mask");

        rsp_ready[1] = 1'b0;
        drive(1, 1'b1, 1'b0, 7'h20, 64'h0, 64'h0);
        #1 check("hold_rdy", req_ready, 2'b10);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 7'h21, 64'h0, 64'h0);
        for (int k = 0; k < 11; k++) begin
            drive(0, 1'b1, 1'b1, 7'(7'h40 + k), 64'(k), '1);
            #1 check($sformatf("hold_arb%0d", k), req_ready, 2'b01);
            if (k > 0) begin
                check($sformatf("hold_v%0d", k), rsp_valid[1], 1);
                check($sformatf("hold_d%0d", k), rsp_rdata[127:64], pat(32));
            end
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        check("hold_wr", dut.u_sram.r_mem[7'h45], 64'h5);
        rsp_ready[1] = 1'b1;
        #1 check("pop_grant", req_ready, 2'b10);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1 check("pop_v1", rsp_valid[1], 0);
        @(negedge clk);
        #1 check("pop_v2", rsp_valid[1], 1);
        check("pop_d", rsp_rdata[127:64], pat(33));
        @(negedge clk);

        drive(0, 1'b1, 1'b1, 7'h10, 64'h3, '1);
        #1 check("raw_w", req_ready, 2'b01);
        @(negedge clk);
        req_valid[0] = 1'b0;
        rd(1, 7'h10, 64'h3, "raw");

        // Reset with a held response on port 0 and a read in flight on port 1
        rsp_ready = 2'b00;
        drive(0, 1'b1, 1'b0, 7'h7F, 64'h0, 64'h0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        drive(1, 1'b1, 1'b0, 7'h11, 64'h0, 64'h0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1 check("pre_rst_v", rsp_valid, 2'b01);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_v", rsp_valid, 0);
        check("mrst_d0", rsp_rdata[63:0], 0);
        check("mrst_d1", rsp_rdata[127:64], 0);
        check("mrst_init", init_done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        drive(0, 1'b1, 1'b0, 7'h7F, 64'h0, 64'h0);
        drive(1, 1'b1, 1'b0, 7'h10, 64'h0, 64'h0);
        seen_v = 1'b0;
        seen_r = 1'b0;
        for (int c = 0; c < 128; c++) begin
            #1 seen_v = seen_v | (|rsp_valid);
            seen_r = seen_r | (|req_ready);
            @(negedge clk);
        end
        #1 check("clr2_init", init_done, 1);
        check("clr2_stale", seen_v, 0);
        check("clr2_rdy", seen_r, 0);
        check("clr2_arb0", req_ready, 2'b01);
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1 check("clr2_arb1", req_ready, 2'b10);
        check("clr2_v0", rsp_valid, 0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1 check("clr2_v1", rsp_valid, 2'b01);
        check("clr2_d7f", rsp_rdata[63:0], 64'h0);
        @(negedge clk);
        #1 check("clr2_v2", rsp_valid, 2'b10);
        check("clr2_d10", rsp_rdata[127:64], 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
